// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants for the padder and the compression core.
package sha256_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [15:0][31:0] block_t;

  localparam word_t PAD_WORD = 32'h8000_0000;

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Keep the first nbytes bytes, put the 0x80 marker right after them, zero the rest.
  function automatic word_t pad_last_word(input word_t data, input logic [1:0] nbytes);
    word_t w;
    unique case (nbytes)
      2'd1:    w = {data[31:24], 8'h80, 16'h0000};
      2'd2:    w = {data[31:16], 8'h80, 8'h00};
      2'd3:    w = {data[31:8], 8'h80};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_block_padder.sv
// Streams 32-bit message words into 512-bit SHA-256 blocks with FIPS 180-4 padding.
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_words,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {StFill, StPad, StEmit} state_e;

  state_e           r_state, w_state_next;
  block_t           r_buf, w_buf_next;
  logic [3:0]       r_widx, w_widx_next;
  logic [LEN_W-1:0] r_bitcnt, w_bitcnt_next;
  logic             r_marker_owed, w_marker_owed_next;
  logic             r_len_hi_done, w_len_hi_done_next;
  logic             r_msg_done, w_msg_done_next;
  logic             r_first, w_first_next;
  logic             r_last, w_last_next;

  logic             w_accept;
  logic [5:0]       w_last_bits;
  logic [63:0]      w_len64;

  assign w_accept    = in_valid && in_ready;
  assign w_last_bits = (in_bytes == 2'd0) ? 6'd32 : {1'b0, in_bytes, 3'b000};
  assign w_len64     = 64'(r_bitcnt);

  // Word i lives in r_buf[15-i], so the packed buffer is already in output bit order.
  assign in_ready  = (r_state == StFill) && !reset;
  assign blk_valid = (r_state == StEmit);
  assign blk_words = r_buf;
  assign blk_first = blk_valid && r_first;
  assign blk_last  = blk_valid && r_last;

  // State and datapath registers; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StFill;
      r_buf         <= '0;
      r_widx        <= '0;
      r_bitcnt      <= '0;
      r_marker_owed <= 1'b0;
      r_len_hi_done <= 1'b0;
      r_msg_done    <= 1'b0;
      r_first       <= 1'b1;
      r_last        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_buf         <= w_buf_next;
      r_widx        <= w_widx_next;
      r_bitcnt      <= w_bitcnt_next;
      r_marker_owed <= w_marker_owed_next;
      r_len_hi_done <= w_len_hi_done_next;
      r_msg_done    <= w_msg_done_next;
      r_first       <= w_first_next;
      r_last        <= w_last_next;
    end
  end

  // Next-state: fill from input, pad one word per cycle, hold the block until taken.
  always_comb begin
    w_state_next       = r_state;
    w_buf_next         = r_buf;
    w_widx_next        = r_widx;
    w_bitcnt_next      = r_bitcnt;
    w_marker_owed_next = r_marker_owed;
    w_len_hi_done_next = r_len_hi_done;
    w_msg_done_next    = r_msg_done;
    w_first_next       = r_first;
    w_last_next        = r_last;

    unique case (r_state)
      StFill: begin
        if (w_accept) begin
          w_buf_next[~r_widx] = in_last ? pad_last_word(in_data, in_bytes) : in_data;
          w_bitcnt_next       = r_bitcnt + (in_last ? LEN_W'(w_last_bits) : LEN_W'(32));
          w_widx_next         = r_widx + 4'd1;
          if (in_last) begin
            w_msg_done_next    = 1'b1;
            w_marker_owed_next = (in_bytes == 2'd0);
            w_last_next        = 1'b0;
            // A full block leaves no room for padding here; emit it and pad a fresh one.
            w_state_next       = (r_widx == 4'd15) ? StEmit : StPad;
          end else if (r_widx == 4'd15) begin
            w_last_next  = 1'b0;
            w_state_next = StEmit;
          end
        end
      end
      StPad: begin
        if (r_marker_owed) begin
          w_buf_next[~r_widx] = PAD_WORD;
          w_marker_owed_next  = 1'b0;
          if (r_widx == 4'd15) begin
            w_last_next  = 1'b0;
            w_state_next = StEmit;
          end else begin
            w_widx_next = r_widx + 4'd1;
          end
        end else if (r_widx == 4'd14) begin
          // Marker is already at index <= 13, so the length fits in this block.
          w_buf_next[~r_widx] = w_len64[63:32];
          w_len_hi_done_next  = 1'b1;
          w_widx_next         = r_widx + 4'd1;
        end else if (r_widx == 4'd15) begin
          w_buf_next[~r_widx] = r_len_hi_done ? w_len64[31:0] : 32'h0;
          w_last_next         = r_len_hi_done;
          w_state_next        = StEmit;
        end else begin
          w_buf_next[~r_widx] = 32'h0;
          w_widx_next         = r_widx + 4'd1;
        end
      end
      StEmit: begin
        if (blk_ready) begin
          w_buf_next         = '0;
          w_widx_next        = '0;
          w_len_hi_done_next = 1'b0;
          if (r_last) begin
            w_bitcnt_next   = '0;
            w_first_next    = 1'b1;
            w_msg_done_next = 1'b0;
            w_state_next    = StFill;
          end else begin
            w_first_next = 1'b0;
            w_state_next = r_msg_done ? StPad : StFill;
          end
        end
      end
      default: w_state_next = StFill;
    endcase
  end

endmodule
